// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Takes the two 7-segment patterns from the two-digit counter and shows
//   them on one shared segment bus, one digit at a time. It blanks both
//   digits at the start of each slot so the previous digit does not ghost
//   onto the next one. It dims the display with a 4-bit PWM. The patterns
//   are snapshotted once per frame, so a digit never changes mid-frame.
//
// Parameters
//   REFRESH_DIV    clock cycles per digit slot (frame = 2*REFRESH_DIV);
//                  must be >= BLANK_CYCLES+16
//   BLANK_CYCLES   cycles at the start of each slot with both digits off;
//                  must be >= 1
//   SEG_ACTIVE_LOW 1: segments light on 0 (blank = 7'h7F); 0: blank = 7'h00
//
// Ports
//   CLK         system clock
//   RST         synchronous reset, active-high
//   seg_1       ones-digit segment pattern
//   seg_10      tens-digit segment pattern
//   en          display enable; 0 forces the display dark
//   brightness  PWM duty code, 0 = off, 15 = full
//   seg_out     shared segment bus (registered)
//   an          active-low digit enables, an[0] = ones, an[1] = tens
//   frame_tick  one-cycle pulse at each frame start (registered)

module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] seg_1,
  input  logic [6:0] seg_10,
  input  logic       en,
  input  logic [3:0] brightness,
  output logic [6:0] seg_out,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int unsigned   CW        = $clog2(REFRESH_DIV);
  localparam logic [6:0]    BLANK_PAT = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {
    DIGIT_ONES = 1'b0,
    DIGIT_TENS = 1'b1
  } digit_t;

  digit_t        sel, sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [6:0]    sh1, sh10;
  logic          slot_end;
  logic          frame_start;
  logic          duty_on;
  logic          lit;
  logic [1:0]    an_nxt;
  logic [6:0]    seg_nxt;

  // Slot counter and digit select; both run regardless of en/brightness
  // so that re-enabling the display resumes in phase.
  always_comb begin
    slot_end    = (cnt == CNT_LAST);
    frame_start = (sel == DIGIT_ONES) && (cnt == '0);
    cnt_nxt     = slot_end ? '0 : cnt + 1'b1;
    sel_nxt     = sel;
    if (slot_end) begin
      sel_nxt = (sel == DIGIT_ONES) ? DIGIT_TENS : DIGIT_ONES;
    end
  end

  // PWM compares the low nibble of the slot counter against the duty code.
  // Code 15 is special-cased to full on, because a strict compare would
  // leave one dark cycle in every 16.
  always_comb begin
    duty_on = (brightness == 4'hF) || (cnt[3:0] < brightness);
    lit     = en && (cnt >= BLANK_END) && duty_on;
  end

  // Output decode from the current state. It is registered below, so the
  // pins lag the state by exactly one cycle. Only one enable can be low.
  always_comb begin
    an_nxt  = 2'b11;
    seg_nxt = BLANK_PAT;
    if (lit) begin
      if (sel == DIGIT_ONES) begin
        an_nxt  = 2'b10;
        seg_nxt = sh1;
      end else begin
        an_nxt  = 2'b01;
        seg_nxt = sh10;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      sel <= DIGIT_ONES;
    end else begin
      cnt <= cnt_nxt;
      sel <= sel_nxt;
    end
  end

  // Shadows load only at frame start. The blanking window (>= 1 cycle)
  // guarantees the first lit output already sees the new snapshot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sh1  <= BLANK_PAT;
      sh10 <= BLANK_PAT;
    end else if (frame_start) begin
      sh1  <= seg_1;
      sh10 <= seg_10;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      an         <= 2'b11;
      seg_out    <= BLANK_PAT;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg_out    <= seg_nxt;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (REFRESH_DIV=32, BLANK_CYCLES=4).
// Stimulus is applied on the falling edge. Each applied vector pushes the
// output expected after the following rising edge. The expectation comes
// from the position j (0..63) in the frame: ones slot = j 0..31, tens slot =
// j 32..63, first 4 cycles of each slot dark. A monitor pops the entries
// just after each rising edge and compares them.

module tb_seg_scan_driver;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] seg_1;
  logic [6:0] seg_10;
  logic       en;
  logic [3:0] brightness;
  logic [6:0] seg_out;
  logic [1:0] an;
  logic       frame_tick;

  always #5 CLK = ~CLK;

  seg_scan_driver #(
    .REFRESH_DIV   (32),
    .BLANK_CYCLES  (4),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .seg_1     (seg_1),
    .seg_10    (seg_10),
    .en        (en),
    .brightness(brightness),
    .seg_out   (seg_out),
    .an        (an),
    .frame_tick(frame_tick)
  );

  typedef struct {
    logic [1:0] an;
    logic [6:0] seg;
    logic       ft;
    int         sc;
    int         n;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int scen  = 0;
  int seqn  = 0;
  int j     = 0;           // frame position of the state the next edge uses
  logic [6:0] m_sh1  = 7'h7F;
  logic [6:0] m_sh10 = 7'h7F;

  // Apply one vector and queue the output expected after the next edge.
  task automatic drive(input logic r, input logic [6:0] s1, input logic [6:0] s10,
                       input logic e, input logic [3:0] b);
    exp_t x;
    int   c;
    logic on;
    @(negedge CLK);
    RST = r; seg_1 = s1; seg_10 = s10; en = e; brightness = b;
    x.sc = scen;
    x.n  = seqn;
    seqn++;
    if (r) begin
      x.an = 2'b11; x.seg = 7'h7F; x.ft = 1'b0;
      m_sh1 = 7'h7F; m_sh10 = 7'h7F;
      j = 0;
    end else begin
      if (j == 0) begin
        m_sh1  = s1;
        m_sh10 = s10;
      end
      c    = j % 32;
      on   = e && (c >= 4) && ((b == 4'd15) || ((c % 16) < int'(b)));
      x.ft = (j == 0);
      if (!on) begin
        x.an = 2'b11; x.seg = 7'h7F;
      end else if (j < 32) begin
        x.an = 2'b10; x.seg = m_sh1;
      end else begin
        x.an = 2'b01; x.seg = m_sh10;
      end
      j = (j + 1) % 64;
    end
    sb.push_back(x);
  endtask

  // Monitor: one scoreboard entry per cycle, plus the structural invariant.
  initial begin
    exp_t x;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total++;
        if (an !== x.an || seg_out !== x.seg || frame_tick !== x.ft) begin
          bad++;
          $display("FAIL out_sc%0d n=%0d: got an=%b seg=%h ft=%b, want an=%b seg=%h ft=%b",
                   x.sc, x.n, an, seg_out, frame_tick, x.an, x.seg, x.ft);
        end
        total++;
        if (an === 2'b00 || (an === 2'b11 && seg_out !== 7'h7F)) begin
          bad++;
          $display("FAIL invariant_sc%0d n=%0d: got an=%b seg=%h, want an!=00 and blank when dark",
                   x.sc, x.n, an, seg_out);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; seg_1 = 7'h40; seg_10 = 7'h79; en = 1'b1; brightness = 4'd15;

    // 1: reset held 10 cycles, then two full frames at full brightness
    scen = 1;
    repeat (10) drive(1'b1, 7'h40, 7'h79, 1'b1, 4'd15);
    repeat (128) drive(1'b0, 7'h40, 7'h79, 1'b1, 4'd15);

    // 2: seg_1 changes mid ones slot; visible only from the next frame
    scen = 2;
    repeat (16) drive(1'b0, 7'h40, 7'h79, 1'b1, 4'd15);
    repeat (112) drive(1'b0, 7'h24, 7'h79, 1'b1, 4'd15);

    // 3: brightness 4, 0, then 15, one frame each
    scen = 3;
    repeat (64) drive(1'b0, 7'h24, 7'h79, 1'b1, 4'd4);
    repeat (64) drive(1'b0, 7'h24, 7'h79, 1'b1, 4'd0);
    repeat (64) drive(1'b0, 7'h24, 7'h79, 1'b1, 4'd15);

    // 4: en dropped for 40 cycles straddling the slot boundary
    scen = 4;
    repeat (10) drive(1'b0, 7'h24, 7'h30, 1'b1, 4'd15);
    repeat (40) drive(1'b0, 7'h24, 7'h30, 1'b0, 4'd15);
    repeat (78) drive(1'b0, 7'h24, 7'h30, 1'b1, 4'd15);

    // 5: single-cycle reset in the middle of the tens slot
    scen = 5;
    repeat (40) drive(1'b0, 7'h24, 7'h30, 1'b1, 4'd15);
    repeat (5) drive(1'b0, 7'h06, 7'h30, 1'b1, 4'd15);
    drive(1'b1, 7'h06, 7'h30, 1'b1, 4'd15);
    repeat (128) drive(1'b0, 7'h06, 7'h30, 1'b1, 4'd15);

    // 6: random patterns, brightness and enable
    scen = 6;
    for (int k = 0; k < 5000; k++) begin
      drive(1'b0, 7'($urandom), 7'($urandom), ($urandom_range(0, 7) != 0),
            4'($urandom_range(0, 15)));
    end

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge CLK);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage for the two-digit counter block.
- Consumes its two 7-segment patterns, seg_1 and seg_10, and time-multiplexes them onto one shared segment bus with two active-low digit enables.
- Adds anti-ghosting blanking between digits, 4-bit brightness PWM, and frame-aligned snapshotting so a digit never tears mid-frame.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; one frame is 2*REFRESH_DIV cycles. Must be ≥ BLANK_CYCLES+16.
- BLANK_CYCLES, 16: cycles at the start of each slot with both digits off. Must be ≥ 1.
- SEG_ACTIVE_LOW, 1: 1 means a segment lights on 0 and the blank pattern is 7'h7F; 0 means the blank pattern is 7'h00.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- seg_1  in  7  ones-digit segment pattern from the counter
- seg_10  in  7  tens-digit segment pattern from the counter
- en  in  1  display enable; 0 forces the display dark
- brightness  in  4  PWM duty code: 0 = off, 15 = full
- seg_out  out  7  shared segment bus
- an  out  2  digit enables, active-low; an[0] = ones, an[1] = tens
- frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high (RST).
- State:
  - slot counter cnt, width clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1.
  - digit select sel: 0 = ones, 1 = tens.
  - shadow registers sh1 and sh10, 7 bits each.
- Counter: cnt increments every cycle. When cnt == REFRESH_DIV-1, the next cycle has cnt = 0 and sel toggles. The counter runs regardless of en and brightness.
- Snapshot: in the cycle where sel==0 and cnt==0, sh1 <= seg_1 and sh10 <= seg_10. This is the only time the shadows load. Input changes at any other time are invisible until the next frame start.
- frame_tick: registered. It is 1 in the cycle immediately after a (sel==0, cnt==0) cycle, otherwise 0.
- Digit-on condition, evaluated from the current state:
  - on = en && (cnt >= BLANK_CYCLES) && (brightness == 15 || cnt[3:0] < brightness)
- Outputs are registered, so the next cycle reflects the current state:
  - If on && sel==0: an = 2'b10, seg_out = sh1.
  - If on && sel==1: an = 2'b01, seg_out = sh10.
  - Otherwise: an = 2'b11, seg_out = blank pattern.
- Latency: exactly 1 cycle from state to pins.
  - The shadow load and the first output using it are separated by at least the blanking window, so no stale pattern is ever shown at slot start.
- Invariant: an is never 2'b00 in any cycle, including across a sel toggle.
  - When an digit is on, seg_out equals that digit's shadow.
  - When an == 2'b11, seg_out is the blank pattern.
- Reset (RST=1 at a clock edge), effective the next cycle, with priority over everything:
  - cnt = 0, sel = 0.
  - sh1 = sh10 = blank pattern.
  - an = 2'b11, seg_out = blank pattern, frame_tick = 0.
- After RST deasserts:
  - The first cycle is (sel=0, cnt=0), which loads the shadows.
  - frame_tick pulses the following cycle.
  - Reset held for N cycles keeps the outputs at their reset values for all N cycles.
  - Reset asserted mid-slot or mid-frame aborts immediately; no partial digit is shown afterward.
- en=0: outputs go dark the cycle after en is sampled low. Counter, shadows and frame_tick continue unchanged, so re-enabling resumes in phase.
- brightness may change any cycle; it takes effect on the next output update. There is no glitch beyond the normal 1-cycle latency.

Test Plan:
1. Reset and first frame.
   - Setup: REFRESH_DIV=32, BLANK_CYCLES=4, SEG_ACTIVE_LOW=1. RST=1 for 10 cycles, seg_1=7'h40, seg_10=7'h79, brightness=15, en=1, then RST=0.
   - Check: during reset an=2'b11, seg_out=7'h7F. frame_tick pulses exactly 2 cycles after RST falls.
   - Check: an=2'b10 with seg_out=7'h40 for 28 consecutive cycles, then 4 blank cycles, then an=2'b01 with seg_out=7'h79 for 28 cycles.
   - Check: frame_tick period is 64 cycles.
2. Tear-free update.
   - Stimulus: change seg_1 to 7'h24 in the middle of the ones slot.
   - Check: seg_out stays 7'h40 for the rest of that frame. 7'h24 first appears in the ones slot of the next frame.
3. Brightness.
   - Stimulus: brightness=4.
   - Check: within each active window, an is low only in cycles following cnt[3:0] ∈ {0,1,2,3}, i.e. 4 of every 16 cycles.
   - Check: brightness=0 gives an=2'b11 throughout. brightness=15 gives 28/28 on.
4. Enable gating.
   - Stimulus: drop en for 40 cycles.
   - Check: an=2'b11 from the next cycle, and the frame_tick spacing stays 64 throughout.
   - Check: on re-enable, digit phase is unchanged.
5. Reset mid-operation.
   - Stimulus: assert RST for 1 cycle mid tens-slot.
   - Check: the next cycle has an=2'b11, seg_out=7'h7F.
   - Check: the sequence restarts exactly as in scenario 1, with the ones digit showing the current seg_1.
6. Invariant sweep.
   - Stimulus: random seg inputs, brightness and en over 5000 cycles.
   - Check: an != 2'b00 in every cycle, and seg_out == blank whenever an == 2'b11.
